// File: rtl/component_tracker_mp.sv
// component_tracker_mp: per-antenna P=sum(re+im) / M=sum(re-im) accumulator
// feeding a double-buffered antenna store, read out as baseline corrections.
// Optional build macro: COMPONENT_TRACKER_SAT_EN (saturate instead of wrap
// when OUT_WIDTH is narrower than the exact result).
module component_tracker_mp #(
  parameter int N_ANTS              = 32,
  parameter int N_POLS              = 2,
  parameter int P_FACTOR_BITS       = 2,
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int BITWIDTH            = 4,
  parameter int OUT_WIDTH           = BITWIDTH + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS + 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        sync,
  input  logic [N_POLS*(1<<P_FACTOR_BITS)*2*BITWIDTH-1:0] din,
  input  logic                                        din_vld,
  output logic [N_POLS*N_POLS*OUT_WIDTH-1:0]          re_corr,
  output logic [N_POLS*N_POLS*OUT_WIDTH-1:0]          im_corr,
  output logic [$clog2(N_ANTS)-1:0]                   ant_a,
  output logic [$clog2(N_ANTS)-1:0]                   ant_b,
  output logic                                        last_bl,
  output logic                                        dout_vld,
  input  logic                                        dout_rdy,
  output logic                                        ovf
);

  localparam int P      = 1 << P_FACTOR_BITS;
  localparam int ACC_W  = BITWIDTH + 1 + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS;
  localparam int NPP    = N_POLS * N_POLS;
  localparam int SUM_W  = ACC_W + 1;
  localparam int WIDE_W = (OUT_WIDTH > SUM_W) ? OUT_WIDTH : SUM_W;
  localparam int ANT_W  = $clog2(N_ANTS);
  localparam int ENT_W  = 2 * N_POLS * ACC_W;
  localparam int DEPTH  = 2 * N_ANTS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ANT_W-1:0] ANT_LAST = ANT_W'(N_ANTS - 1);
  localparam logic [SERIAL_ACC_LEN_BITS-1:0] CYC_LAST = '1;

  // input side
  logic                           synced_reg;
  logic [SERIAL_ACC_LEN_BITS-1:0] cyc_cnt_reg;
  logic [ANT_W-1:0]               ant_cnt_reg;
  logic                           accept;
  logic                           ant_done;
  logic                           frame_done;
  logic [ENT_W-1:0]               wr_ent;

  // bank store: bank 0 at addresses 0..N_ANTS-1, bank 1 above it
  logic [ENT_W-1:0]               mem_reg [DEPTH];
  logic                           wr_bank_reg;
  logic                           rd_bank_reg;

  // reader side
  logic                           rd_busy_reg;
  logic [ANT_W-1:0]               rd_a_reg;
  logic [ANT_W-1:0]               rd_b_reg;
  logic                           rd_last;
  logic                           reader_idle;
  logic                           load;
  logic [ENT_W-1:0]               ent_a;
  logic [ENT_W-1:0]               ent_b;
  logic [NPP*OUT_WIDTH-1:0]       re_fit;
  logic [NPP*OUT_WIDTH-1:0]       im_fit;

  function automatic logic [ADDR_W-1:0] mem_addr(input logic bank, input logic [ANT_W-1:0] ant);
    mem_addr = bank ? (ADDR_W'(ant) + ADDR_W'(N_ANTS)) : ADDR_W'(ant);
  endfunction

  // Data before the first sync, and the sync cycle itself, carry no frame data.
  assign accept     = synced_reg && din_vld && !sync;
  assign ant_done   = accept && (cyc_cnt_reg == CYC_LAST);
  assign frame_done = ant_done && (ant_cnt_reg == ANT_LAST);

  // Per-polarisation sum of P samples this cycle, accumulated over L valid cycles.
  for (genvar gi = 0; gi < N_POLS; gi++) begin : g_pol
    logic signed [BITWIDTH-1:0] re_s;
    logic signed [BITWIDTH-1:0] im_s;
    logic signed [ACC_W-1:0]    cyc_p;
    logic signed [ACC_W-1:0]    cyc_m;
    logic signed [ACC_W-1:0]    acc_p_reg;
    logic signed [ACC_W-1:0]    acc_m_reg;
    logic signed [ACC_W-1:0]    acc_p_next;
    logic signed [ACC_W-1:0]    acc_m_next;

    // Fold this cycle's P samples of this polarisation into re+im and re-im.
    always_comb begin
      re_s  = '0;
      im_s  = '0;
      cyc_p = '0;
      cyc_m = '0;
      for (int i = 0; i < P; i++) begin
        im_s  = $signed(din[(i*N_POLS+gi)*2*BITWIDTH +: BITWIDTH]);
        re_s  = $signed(din[(i*N_POLS+gi)*2*BITWIDTH + BITWIDTH +: BITWIDTH]);
        cyc_p = cyc_p + ACC_W'(re_s) + ACC_W'(im_s);
        cyc_m = cyc_m + ACC_W'(re_s) - ACC_W'(im_s);
      end
    end

    // First cycle of an antenna restarts the sum, so no explicit clear is needed.
    assign acc_p_next = (cyc_cnt_reg == '0) ? cyc_p : (acc_p_reg + cyc_p);
    assign acc_m_next = (cyc_cnt_reg == '0) ? cyc_m : (acc_m_reg + cyc_m);

    assign wr_ent[(2*gi)*ACC_W +: ACC_W]   = acc_p_next;
    assign wr_ent[(2*gi+1)*ACC_W +: ACC_W] = acc_m_next;

    // Running sums for the antenna currently streaming in.
    always_ff @(posedge clk) begin
      if (accept) begin
        acc_p_reg <= acc_p_next;
        acc_m_reg <= acc_m_next;
      end
    end
  end

  // Frame position: sync (after reset) re-arms at antenna 0, cycle 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      synced_reg  <= 1'b0;
      cyc_cnt_reg <= '0;
      ant_cnt_reg <= '0;
    end else if (sync) begin
      synced_reg  <= 1'b1;
      cyc_cnt_reg <= '0;
      ant_cnt_reg <= '0;
    end else if (accept) begin
      cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
      if (ant_done) begin
        ant_cnt_reg <= (ant_cnt_reg == ANT_LAST) ? '0 : (ant_cnt_reg + 1'b1);
      end
    end
  end

  // Completed antenna sums land in the write bank.
  always_ff @(posedge clk) begin
    if (ant_done) begin
      mem_reg[mem_addr(wr_bank_reg, ant_cnt_reg)] <= wr_ent;
    end
  end

  assign ent_a = mem_reg[mem_addr(rd_bank_reg, rd_a_reg)];
  assign ent_b = mem_reg[mem_addr(rd_bank_reg, rd_b_reg)];

  // Baseline field (pa, pb): exact sum/difference, then fit into OUT_WIDTH.
  for (genvar gi = 0; gi < NPP; gi++) begin : g_fld
    localparam int PA = gi / N_POLS;
    localparam int PB = gi % N_POLS;
    logic signed [ACC_W-1:0]  p_a;
    logic signed [ACC_W-1:0]  p_b;
    logic signed [ACC_W-1:0]  m_a;
    logic signed [ACC_W-1:0]  m_b;
    logic signed [WIDE_W-1:0] re_w;
    logic signed [WIDE_W-1:0] im_w;

    assign p_a  = ent_a[(2*PA)*ACC_W +: ACC_W];
    assign m_a  = ent_a[(2*PA+1)*ACC_W +: ACC_W];
    assign p_b  = ent_b[(2*PB)*ACC_W +: ACC_W];
    assign m_b  = ent_b[(2*PB+1)*ACC_W +: ACC_W];
    assign re_w = WIDE_W'(p_a) + WIDE_W'(p_b);
    assign im_w = WIDE_W'(m_b) - WIDE_W'(m_a);

    if (OUT_WIDTH >= SUM_W) begin : g_ext
      assign re_fit[gi*OUT_WIDTH +: OUT_WIDTH] = re_w[OUT_WIDTH-1:0];
      assign im_fit[gi*OUT_WIDTH +: OUT_WIDTH] = im_w[OUT_WIDTH-1:0];
    end else begin : g_fit
`ifdef COMPONENT_TRACKER_SAT_EN
      localparam bit SAT_EN = 1'b1;
`else
      localparam bit SAT_EN = 1'b0;
`endif
      localparam logic [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      localparam logic [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      logic re_ok;
      logic im_ok;
      // In range when every bit from the output sign bit upward agrees.
      assign re_ok = (&re_w[WIDE_W-1:OUT_WIDTH-1]) | ~(|re_w[WIDE_W-1:OUT_WIDTH-1]);
      assign im_ok = (&im_w[WIDE_W-1:OUT_WIDTH-1]) | ~(|im_w[WIDE_W-1:OUT_WIDTH-1]);
      assign re_fit[gi*OUT_WIDTH +: OUT_WIDTH] = (SAT_EN && !re_ok) ?
          (re_w[WIDE_W-1] ? MIN_V : MAX_V) : re_w[OUT_WIDTH-1:0];
      assign im_fit[gi*OUT_WIDTH +: OUT_WIDTH] = (SAT_EN && !im_ok) ?
          (im_w[WIDE_W-1] ? MIN_V : MAX_V) : im_w[OUT_WIDTH-1:0];
    end
  end

  // Idle means nothing left to issue and no word waiting at the output.
  assign reader_idle = !rd_busy_reg && !dout_vld;
  assign rd_last     = (rd_a_reg == ANT_LAST) && (rd_b_reg == ANT_LAST);
  assign load        = rd_busy_reg && (!dout_vld || dout_rdy);

  // Bank swap / drop decision and baseline readout with a single output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      rd_busy_reg <= 1'b0;
      rd_a_reg    <= '0;
      rd_b_reg    <= '0;
      ovf         <= 1'b0;
      dout_vld    <= 1'b0;
      last_bl     <= 1'b0;
      ant_a       <= '0;
      ant_b       <= '0;
      re_corr     <= '0;
      im_corr     <= '0;
    end else begin
      if (frame_done) begin
        if (reader_idle) begin
          rd_bank_reg <= wr_bank_reg;
          wr_bank_reg <= ~wr_bank_reg;
          rd_busy_reg <= 1'b1;
          rd_a_reg    <= '0;
          rd_b_reg    <= '0;
        end else begin
          ovf <= 1'b1;
        end
      end
      if (load) begin
        dout_vld <= 1'b1;
        last_bl  <= rd_last;
        ant_a    <= rd_a_reg;
        ant_b    <= rd_b_reg;
        re_corr  <= re_fit;
        im_corr  <= im_fit;
        if (rd_last) begin
          rd_busy_reg <= 1'b0;
        end else if (rd_b_reg == ANT_LAST) begin
          rd_a_reg <= rd_a_reg + 1'b1;
          rd_b_reg <= rd_a_reg + 1'b1;
        end else begin
          rd_b_reg <= rd_b_reg + 1'b1;
        end
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
        last_bl  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/component_tracker_mp.md
COMPONENT_TRACKER_MP -- requirements
Module: component_tracker_mp

Interface
REQ-001 Parameters SHALL be: N_ANTS, default 32, number of antennas (>=2); N_POLS, default 2, polarisations per antenna (1 or 2); P_FACTOR_BITS, default 2, log2 of parallel samples per cycle; SERIAL_ACC_LEN_BITS, default 7, log2 of valid cycles per antenna; BITWIDTH, default 4, signed re/im width; OUT_WIDTH, default ACC_W+1, correction output width.
REQ-002 Derived widths SHALL be P=1<<P_FACTOR_BITS, L=1<<SERIAL_ACC_LEN_BITS, ACC_W=BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS, NPP=N_POLS*N_POLS.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 sync  in  1  frame start; the next valid cycle carries antenna 0, sample cycle 0.
REQ-007 din  in  N_POLS*P*2*BITWIDTH  sample slot (i*N_POLS+p): im in the low BITWIDTH bits, re in the high BITWIDTH bits, both two's complement.
REQ-008 din_vld  in  1  din is valid this cycle.
REQ-009 re_corr  out  NPP*OUT_WIDTH  real correction; field (pa*N_POLS+pb).
REQ-010 im_corr  out  NPP*OUT_WIDTH  imaginary correction; same field order.
REQ-011 ant_a, ant_b  out  log2(N_ANTS) each  baseline antenna indices.
REQ-012 last_bl  out  1  current output is the final baseline of the bank.
REQ-013 dout_vld  out  1  output word valid.
REQ-014 dout_rdy  in  1  downstream accepts the word when dout_vld and dout_rdy are both high.
REQ-015 ovf  out  1  sticky flag: a completed frame was dropped.

Function
REQ-016 Per antenna k and pol p, the block SHALL accumulate Pk,p = sum(re+im) and Mk,p = sum(re-im) over P samples x L valid cycles, exact at ACC_W signed.
REQ-017 Input order SHALL be antenna-major: L valid cycles for antenna 0, then antenna 1, up to N_ANTS-1; cycles with din_vld=0 are ignored.
REQ-018 Sums SHALL go to a double-buffered store of N_ANTS x N_POLS x {P,M}: a write bank and a read bank.
REQ-019 When the last valid cycle of antenna N_ANTS-1 is accepted and the reader is idle, the banks SHALL swap and readout SHALL start.
REQ-020 If the reader is busy at that moment, the completed bank SHALL be discarded, ovf SHALL be set, and readout SHALL continue unaffected.
REQ-021 A sync SHALL be ignored until the first sync after reset; before then all input is discarded.
REQ-022 A sync mid-frame SHALL discard the partial frame, restart at antenna 0, and leave readout untouched.
REQ-023 Readout SHALL emit baselines for a=0..N_ANTS-1, b=a..N_ANTS-1, in that order: N_ANTS*(N_ANTS+1)/2 words, with last_bl high on the (N_ANTS-1, N_ANTS-1) word.
REQ-024 Each field SHALL be re_corr = Pa,pa + Pb,pb and im_corr = Mb,pb - Ma,pa, computed exactly at ACC_W+1 bits.
REQ-025 The first dout_vld SHALL assert within 4 cycles of the swap.
REQ-026 While dout_vld=1 and dout_rdy=0, all outputs SHALL hold stable; after an accepted word, the next word MAY follow on the next cycle (full throughput).
REQ-027 The reader SHALL become idle the cycle after the last_bl word is accepted.

Reset
REQ-028 rst SHALL clear dout_vld, last_bl, ovf, ant_a, ant_b, re_corr and im_corr to 0, clear all counters, and mark both banks empty.
REQ-029 rst SHALL take effect mid-frame or mid-readout with no further output words, and the block SHALL wait for a new sync.

Configuration
REQ-030 When COMPONENT_TRACKER_SAT_EN is defined, each ACC_W+1 result SHALL saturate to the signed OUT_WIDTH range.
REQ-031 When COMPONENT_TRACKER_SAT_EN is undefined, each result SHALL be truncated to its OUT_WIDTH LSBs (wrap).
REQ-032 The macro SHALL have no effect when OUT_WIDTH >= ACC_W+1.

Verification
Bench parameters: N_ANTS=4, N_POLS=1, P_FACTOR_BITS=1, SERIAL_ACC_LEN_BITS=2, BITWIDTH=4, dout_rdy=1 unless stated.
REQ-033 Basic: sync, then antenna k fed re=k, im=1 -> 10 words in order (0,0)..(3,3); word (1,3) gives re_corr=48, im_corr=16; last_bl only on (3,3).
REQ-034 Backpressure: dout_rdy toggled 1/0 every cycle during readout -> outputs stable while stalled; exactly 10 accepted words, values identical to REQ-033.
REQ-035 Overflow: dout_rdy=0 and a second full frame supplied -> ovf=1 at second-frame completion; after release, first-frame data is read unchanged; ovf stays 1 until rst.
REQ-036 Saturation: OUT_WIDTH=6, all samples re=7, im=7 -> word (0,0) re_corr=31 with macro defined, -32 without; im_corr=0 in both cases.
REQ-037 Sync mid-frame: new sync after 2 antennas -> those partial sums are discarded; the next full frame yields the REQ-033 values.
REQ-038 Reset mid-readout: rst asserted after 3 accepted words -> dout_vld=0 the next cycle, ovf=0, no further words until a new complete frame arrives.
